// File: rtl/clock_divider_bank.sv
// Bank of runtime-programmable 50% duty clock dividers with per-channel tick pulses.
// Half-period writes land in a shadow register and reach the counter only at a wrap, sync or while disabled.
module clock_divider_bank #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = 4999,
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_data_i,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] tick_o
);

  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [CNT_W-1:0]  active_q [NUM_CH];
  logic [CNT_W-1:0]  active_d [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  // Out-of-range channel addresses match no channel and are dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i]  = shadow_q[i];
      active_d[i]  = active_q[i];
      count_d[i]   = count_q[i];
      clk_out_d[i] = clk_out_q[i];
      tick_d[i]    = 1'b0;

      if (wr_en_i && (32'(wr_ch_i) == 32'(i))) begin
        shadow_d[i] = wr_data_i;
      end

      // Every point where active reloads uses the post-write shadow value.
      if (sync_i || !en_i[i]) begin
        count_d[i]   = '0;
        clk_out_d[i] = 1'b0;
        active_d[i]  = shadow_d[i];
      end else if (count_q[i] == active_q[i]) begin
        count_d[i]   = '0;
        clk_out_d[i] = ~clk_out_q[i];
        tick_d[i]    = ~clk_out_q[i];
        active_d[i]  = shadow_d[i];
      end else begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= CNT_W'(DEFAULT_HALF);
        active_q[i] <= CNT_W'(DEFAULT_HALF);
        count_q[i]  <= '0;
      end
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        count_q[i]  <= count_d[i];
      end
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: stimulus queues expected clk_out transitions,
// a negedge monitor pops and checks them (cycle, direction, coincident tick).
module tb_clock_divider_bank;

  localparam int unsigned NCH  = 3;
  localparam int unsigned CW   = 16;
  localparam int unsigned CHW  = 2;
  localparam int unsigned HDEF = 4999;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NCH-1:0]  en_i;
  logic            sync_i;
  logic            wr_en_i;
  logic [CHW-1:0]  wr_ch_i;
  logic [CW-1:0]   wr_data_i;
  logic [NCH-1:0]  clk_out_o;
  logic [NCH-1:0]  tick_o;

  clock_divider_bank #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_HALF(HDEF)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .sync_i   (sync_i),
    .wr_en_i  (wr_en_i),
    .wr_ch_i  (wr_ch_i),
    .wr_data_i(wr_data_i),
    .clk_out_o(clk_out_o),
    .tick_o   (tick_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int ch;
    int cyc;
    bit rise;
  } ev_t;

  ev_t            exp_q[$];
  int             cyc    = 0;
  int             n_chk  = 0;
  int             n_pass = 0;
  bit             mon_en = 1'b0;
  logic [NCH-1:0] prev   = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic push_ev(input int ch, input int c, input bit r);
    ev_t e;
    e.ch = ch; e.cyc = c; e.rise = r;
    exp_q.push_back(e);
  endtask

  // Free-running channel enabled at the negedge of cycle s with half-period h.
  task automatic push_run(input int ch, input int s, input int h, input int last);
    for (int k = 1; s + k * (h + 1) <= last; k++)
      push_ev(ch, s + k * (h + 1), (k % 2) == 1);
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk_i);
  endtask

  task automatic wr(input int ch, input int d);
    wr_en_i   = 1'b1;
    wr_ch_i   = CHW'(ch);
    wr_data_i = CW'(d);
  endtask

  task automatic chk(input string nm, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got=%b want=%b (cyc %0d)", nm, got, want, cyc);
  endtask

  // Monitor: every clk_out transition must match the oldest queued event of its channel.
  always @(negedge clk_i) begin
    int  idx;
    ev_t e;
    if (mon_en) begin
      for (int c = 0; c < NCH; c++) begin
        if (clk_out_o[c] !== prev[c]) begin
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k].ch == c) begin
              idx = k;
              break;
            end
          end
          n_chk++;
          if (idx < 0) begin
            $display("FAIL unexpected_edge ch%0d: got level=%b at cyc %0d, required no transition",
                     c, clk_out_o[c], cyc);
          end else begin
            e = exp_q[idx];
            exp_q.delete(idx);
            if (e.cyc == cyc && e.rise == clk_out_o[c] && tick_o[c] === clk_out_o[c])
              n_pass++;
            else
              $display("FAIL edge ch%0d: got cyc=%0d level=%b tick=%b, required cyc=%0d level=%b tick=%b",
                       c, cyc, clk_out_o[c], tick_o[c], e.cyc, e.rise, e.rise);
          end
          prev[c] = clk_out_o[c];
        end else if (tick_o[c] !== 1'b0) begin
          n_chk++;
          $display("FAIL spurious_tick ch%0d: got tick=%b at cyc %0d, required 0", c, tick_o[c], cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at cyc %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int r;
    rst_i = 1'b1; en_i = '0; sync_i = 1'b0; wr_en_i = 1'b0; wr_ch_i = '0; wr_data_i = '0;
    repeat (3) nxt();
    rst_i = 1'b0;
    nxt();
    chk("reset_clk_out", clk_out_o, '0);
    chk("reset_tick", tick_o, '0);
    mon_en = 1'b1;

    // Default ratio on all channels: rise after 5000 edges, fall 5000 later.
    en_i = '1;
    s = cyc;
    for (int c = 0; c < NCH; c++) push_run(c, s, int'(HDEF), s + 10000);
    wait_until(s + 10000);
    en_i = '0;

    // Disabled channel adopts a write immediately; ch0 runs alongside untouched.
    nxt();
    wr(1, 2);
    nxt();
    wr_en_i = 1'b0;
    en_i = 3'b011;
    s = cyc;
    push_run(1, s, 2, s + 20);
    wait_until(s + 20);
    en_i = '0;

    // Ratio change written mid high-phase: current half finishes at 4, then halves of 2.
    nxt();
    wr(0, 3);
    nxt();
    wr_en_i = 1'b0;
    en_i = 3'b001;
    s = cyc;
    push_ev(0, s + 4, 1); push_ev(0, s + 8, 0); push_ev(0, s + 10, 1);
    push_ev(0, s + 12, 0); push_ev(0, s + 14, 1); push_ev(0, s + 16, 0);
    wait_until(s + 5);
    wr(0, 1);
    nxt();
    wr_en_i = 1'b0;
    wait_until(s + 17);
    en_i = '0;

    // Write coincident with the wrap edge is used for the very next half-period.
    nxt();
    wr(0, 3);
    nxt();
    wr_en_i = 1'b0;
    en_i = 3'b001;
    s = cyc;
    push_ev(0, s + 4, 1); push_ev(0, s + 8, 0); push_ev(0, s + 10, 1);
    push_ev(0, s + 12, 0); push_ev(0, s + 14, 1); push_ev(0, s + 16, 0);
    wait_until(s + 7);
    wr(0, 1);
    nxt();
    wr_en_i = 1'b0;
    wait_until(s + 15);
    en_i = '0;

    // H = 0: toggle every edge.
    nxt();
    wr(0, 0);
    nxt();
    wr_en_i = 1'b0;
    en_i = 3'b001;
    s = cyc;
    push_run(0, s, 0, s + 10);
    wait_until(s + 10);
    en_i = '0;

    // Sync mid high-phase on two channels, then out-of-range write.
    nxt();
    wr(0, 1);
    nxt();
    wr(1, 2);
    nxt();
    wr_en_i = 1'b0;
    en_i = 3'b011;
    s = cyc;
    push_ev(0, s + 2, 1);  push_ev(0, s + 4, 0);  push_ev(0, s + 6, 1);
    push_ev(0, s + 8, 0);  push_ev(0, s + 10, 1); push_ev(0, s + 11, 0);
    push_ev(0, s + 13, 1); push_ev(0, s + 15, 0); push_ev(0, s + 17, 1);
    push_ev(0, s + 19, 0);
    push_ev(1, s + 3, 1);  push_ev(1, s + 6, 0);  push_ev(1, s + 9, 1);
    push_ev(1, s + 11, 0); push_ev(1, s + 14, 1); push_ev(1, s + 17, 0);
    push_ev(1, s + 20, 1); push_ev(1, s + 21, 0);
    wait_until(s + 10);
    sync_i = 1'b1;
    nxt();
    sync_i = 1'b0;
    wait_until(s + 12);
    wr(3, 0);
    nxt();
    wr_en_i = 1'b0;
    wait_until(s + 20);
    en_i = '0;

    // Maximum half-period on ch2.
    nxt();
    wr(2, 16'hFFFF);
    nxt();
    wr_en_i = 1'b0;
    en_i = 3'b100;
    s = cyc;
    push_ev(2, s + 65536, 1);
    push_ev(2, s + 65537, 0);
    wait_until(s + 65536);
    en_i = '0;

    // Reset mid high-phase with a write pending: write is lost, defaults restored.
    nxt();
    en_i = 3'b011;
    s = cyc;
    push_ev(0, s + 2, 1); push_ev(0, s + 4, 0);
    push_ev(1, s + 3, 1); push_ev(1, s + 4, 0);
    wait_until(s + 3);
    rst_i = 1'b1;
    wr(0, 7);
    nxt();
    rst_i = 1'b0;
    wr_en_i = 1'b0;
    r = cyc;
    chk("midreset_clk_out", clk_out_o, '0);
    chk("midreset_tick", tick_o, '0);
    push_ev(0, r + int'(HDEF) + 1, 1); push_ev(0, r + int'(HDEF) + 2, 0);
    push_ev(1, r + int'(HDEF) + 1, 1); push_ev(1, r + int'(HDEF) + 2, 0);
    wait_until(r + int'(HDEF) + 1);
    en_i = '0;
    repeat (4) nxt();

    while (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL missing_edge ch%0d: got no transition, required level=%b at cyc %0d",
               exp_q[0].ch, exp_q[0].rise, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
